tag_lookup_seq: RTL and testbench
=================================

Name: tag_lookup_seq

Overview:
- Sequential tag-lookup controller for one cache set.
- Shares a single tag-compare datapath across WAYS ways, one way per cycle. The datapath is an XNOR of the request tag against one way tag, followed by an and_wordgate AND reduction.
- Reports hit/way or miss/victim way to the cache control FSM.
- Victim choice uses the AND reduction of the way valid bits (set full) plus a round-robin pointer.

Parameters:
- TAG_W, 8, tag width in bits; also the width of the compare AND reduction.
- WAYS, 4, ways per set; must be a power of 2 and at least 2.
- WAY_W, $clog2(WAYS), way index width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  lookup request strobe.
- req_ready  output  1  high only in IDLE.
- req_tag  input  TAG_W  tag to look up.
- way_tags  input  WAYS*TAG_W  way tags of the set, flattened; way i occupies bits [i*TAG_W +: TAG_W].
- way_valid  input  WAYS  per-way valid bits.
- resp_valid  output  1  result available; held until accepted.
- resp_ready  input  1  consumer accepts the result.
- resp_hit  output  1  1 = hit, 0 = miss.
- resp_way  output  WAY_W  hit way on a hit; victim way on a miss.
- set_full  output  1  AND of the snapshotted way_valid; meaningful while resp_valid is high.

Behaviour:
- Reset values: state IDLE, resp_valid=0, resp_hit=0, resp_way=0, set_full=0, idx=0, rr_ptr=0. req_ready=1 during and after reset.
- Asserting rst mid-lookup or mid-response aborts the operation. No response is produced for the aborted request.
- IDLE: when req_valid is high, capture req_tag, way_tags and way_valid into snapshot registers, set idx=0 and go to CMP. Inputs are ignored after capture.
- CMP, each cycle: match = snap_valid[idx] & AND_reduce(~(tag ^ snap_tag[idx])).
  - Match: go to RESP with resp_hit=1 and resp_way=idx.
  - No match and idx==WAYS-1: go to RESP with resp_hit=0 and resp_way=victim.
  - Otherwise: idx <= idx+1.
  - The lowest matching way wins; later ways are not examined.
- Victim selection:
  - If any snapshotted way is invalid, the victim is the lowest-index invalid way and rr_ptr is unchanged.
  - If all ways are valid (set_full=1), the victim is rr_ptr, and rr_ptr <= rr_ptr+1 (wraps from WAYS-1 to 0) when the miss response is accepted.
- Latency from the accepting edge:
  - Hit in way k: resp_valid rises k+1 edges later.
  - Miss: resp_valid rises WAYS edges later.
- RESP:
  - resp_valid=1; resp_hit, resp_way and set_full stay stable until resp_ready is high at a rising edge.
  - On that edge: resp_valid <= 0 and the FSM returns to IDLE.
  - A new request is accepted no earlier than the edge after the response handshake; there is no request/response overlap.
- req_valid while busy has no effect; the requester must hold the request until req_ready is high.
- The ports are 2-state; no X propagation is required.

Decomposition:
- Shared package cache_pkg holds:
  - TAG_W and WAYS defaults.
  - State encoding: IDLE=2'd0, CMP=2'd1, RESP=2'd2.
- Sub-module tag_match (tag_a, tag_b, valid -> match) instantiates and_wordgate #(.w(TAG_W)) over the XNOR vector.
- A second and_wordgate #(.w(WAYS)) computes set_full in the top level.

Test Plan (TAG_W=8, WAYS=4):
- Hit in way 2: tags {0x11,0x22,0x33,0x44}, valid=4'b1111, req_tag=0x33 -> resp_valid 3 edges after accept, resp_hit=1, resp_way=2, set_full=1.
- Duplicate tags with the lowest way winning: tags {0x5A,0x5A,0,0}, valid=4'b0011, req_tag=0x5A -> resp_hit=1, resp_way=0, latency 1.
- Invalid way with a matching tag: tags all 0x7F, valid=4'b1010, req_tag=0x7F -> hit way 1. Same case with valid=4'b0000 -> miss, resp_way=0, set_full=0, latency 4.
- Round-robin victim with a full set:
  - Four back-to-back misses, valid=4'b1111, tags {1,2,3,4}, req_tag=0x99 -> resp_way sequence 0,1,2,3, then 0 on the fifth miss.
  - resp_ready held low 5 cycles -> outputs stable, rr_ptr unchanged until the handshake.
- Victim is the first invalid way: valid=4'b1011, req_tag miss -> resp_way=2, rr_ptr unchanged.
- Reset mid-lookup: assert rst during CMP with idx=1 -> resp_valid stays 0, req_ready=1 after release. A fresh request then resolves normally.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the cache set tag-lookup slice: default geometry and
// the lookup controller state encoding.
package cache_pkg;

  localparam int DEF_TAG_W = 8;
  localparam int DEF_WAYS  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } lookup_state_t;

endpackage

// File: rtl/and_wordgate.sv
// Wide AND reduction gate used for tag equality and set-full detection.
module and_wordgate #(
  parameter int w = 8
) (
  input  logic [w-1:0] a,
  output logic         y
);

  assign y = &a;

endmodule

// File: rtl/tag_match.sv
// Single-way tag comparator: bitwise XNOR followed by a word AND, qualified by
// the way's valid bit.
module tag_match
  import cache_pkg::*;
#(
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic [TAG_W-1:0] tag_a,
  input  logic [TAG_W-1:0] tag_b,
  input  logic             valid,
  output logic             match
);

  logic [TAG_W-1:0] eq_bits_s;
  logic             all_eq_s;

  assign eq_bits_s = ~(tag_a ^ tag_b);

  and_wordgate #(.w(TAG_W)) u_eq_and (
    .a (eq_bits_s),
    .y (all_eq_s)
  );

  assign match = valid & all_eq_s;

endmodule

// File: rtl/tag_lookup_seq.sv
// Sequential tag-lookup controller for one cache set: walks the ways through a
// single shared comparator and reports hit/way or miss/victim.
module tag_lookup_seq
  import cache_pkg::*;
#(
  parameter  int TAG_W = DEF_TAG_W,
  parameter  int WAYS  = DEF_WAYS,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [TAG_W-1:0]      req_tag,
  input  logic [WAYS*TAG_W-1:0] way_tags,
  input  logic [WAYS-1:0]       way_valid,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_hit,
  output logic [WAY_W-1:0]      resp_way,
  output logic                  set_full
);

  lookup_state_t               state_r;
  logic [WAY_W-1:0]            idx_r;
  logic [WAY_W-1:0]            rr_ptr_r;
  logic [TAG_W-1:0]            snap_tag_r;
  logic [WAYS-1:0][TAG_W-1:0]  snap_tags_r;
  logic [WAYS-1:0]             snap_valid_r;
  logic                        req_ready_r;
  logic                        resp_valid_r;
  logic                        resp_hit_r;
  logic [WAY_W-1:0]            resp_way_r;
  logic                        set_full_r;

  logic                        match_s;
  logic                        set_full_s;
  logic                        last_way_s;
  logic [WAY_W-1:0]            victim_s;

  function automatic logic [WAY_W-1:0] first_invalid(input logic [WAYS-1:0] v);
    logic [WAY_W-1:0] w;
    w = {WAY_W{1'b0}};
    // Scan downwards so the lowest invalid index is the one that sticks.
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!v[i]) begin
        w = WAY_W'(i);
      end
    end
    return w;
  endfunction

  tag_match #(.TAG_W(TAG_W)) u_tag_match (
    .tag_a (snap_tag_r),
    .tag_b (snap_tags_r[idx_r]),
    .valid (snap_valid_r[idx_r]),
    .match (match_s)
  );

  and_wordgate #(.w(WAYS)) u_full_and (
    .a (snap_valid_r),
    .y (set_full_s)
  );

  assign last_way_s = (idx_r == WAY_W'(WAYS - 1));

  // Victim choice: first free way, otherwise the round-robin pointer.
  always_comb begin
    victim_s = {WAY_W{1'b0}};
    if (set_full_s) begin
      victim_s = rr_ptr_r;
    end else begin
      victim_s = first_invalid(snap_valid_r);
    end
  end

  // Lookup FSM with snapshot capture, way walk and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      idx_r        <= {WAY_W{1'b0}};
      rr_ptr_r     <= {WAY_W{1'b0}};
      snap_tag_r   <= {TAG_W{1'b0}};
      snap_tags_r  <= {(WAYS*TAG_W){1'b0}};
      snap_valid_r <= {WAYS{1'b0}};
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_hit_r   <= 1'b0;
      resp_way_r   <= {WAY_W{1'b0}};
      set_full_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            snap_tag_r   <= req_tag;
            snap_tags_r  <= way_tags;
            snap_valid_r <= way_valid;
            idx_r        <= {WAY_W{1'b0}};
            req_ready_r  <= 1'b0;
            state_r      <= CMP;
          end
        end
        CMP: begin
          if (match_s) begin
            resp_valid_r <= 1'b1;
            resp_hit_r   <= 1'b1;
            resp_way_r   <= idx_r;
            set_full_r   <= set_full_s;
            state_r      <= RESP;
          end else if (last_way_s) begin
            resp_valid_r <= 1'b1;
            resp_hit_r   <= 1'b0;
            resp_way_r   <= victim_s;
            set_full_r   <= set_full_s;
            state_r      <= RESP;
          end else begin
            idx_r <= idx_r + WAY_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
            req_ready_r  <= 1'b1;
            state_r      <= IDLE;
            // Only a full-set eviction consumes a round-robin slot.
            if (!resp_hit_r && set_full_r) begin
              rr_ptr_r <= rr_ptr_r + WAY_W'(1);
            end
          end
        end
        default: begin
          state_r      <= IDLE;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_hit   = resp_hit_r;
  assign resp_way   = resp_way_r;
  assign set_full   = set_full_r;

endmodule

// File: tb/tb_tag_lookup_seq.sv
// Self-checking bench for tag_lookup_seq (TAG_W=8, WAYS=4) against a
// behavioural set-lookup model with literal pins on selected vectors.
module tb_tag_lookup_seq;

  localparam int TAG_W = 8;
  localparam int WAYS  = 4;
  localparam int WAY_W = 2;

  logic                  clk;
  logic                  rst;
  logic                  req_valid;
  logic                  req_ready;
  logic [TAG_W-1:0]      req_tag;
  logic [WAYS*TAG_W-1:0] way_tags;
  logic [WAYS-1:0]       way_valid;
  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_hit;
  logic [WAY_W-1:0]      resp_way;
  logic                  set_full;

  int checks = 0;
  int errors = 0;

  // model state
  int   rr_m    = 0;
  logic busy_m  = 1'b0;
  logic exp_hit = 1'b0;
  int   exp_way = 0;
  logic exp_full = 1'b0;

  tag_lookup_seq #(.TAG_W(TAG_W), .WAYS(WAYS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_tag    (req_tag),
    .way_tags   (way_tags),
    .way_valid  (way_valid),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_hit   (resp_hit),
    .resp_way   (resp_way),
    .set_full   (set_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Per-cycle compare against the model whenever outputs are meaningful.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (req_ready !== !busy_m) begin
        errors++;
        $display("FAIL req_ready: got %0b expected %0b", req_ready, !busy_m);
      end
      if (resp_valid) begin
        checks++;
        if (resp_hit !== exp_hit || int'(resp_way) != exp_way || set_full !== exp_full) begin
          errors++;
          $display("FAIL resp_fields: got hit=%0b way=%0d full=%0b expected hit=%0b way=%0d full=%0b",
                   resp_hit, resp_way, set_full, exp_hit, exp_way, exp_full);
        end
      end
    end
  end

  // Behavioural lookup: lowest valid matching way, else first free way or round-robin.
  task automatic model(input logic [WAYS*TAG_W-1:0] tags, input logic [WAYS-1:0] vld,
                       input logic [TAG_W-1:0] tag,
                       output logic hit, output int way, output logic full, output int lat);
    logic [TAG_W-1:0] t;
    int free_way;
    hit = 1'b0;
    way = 0;
    lat = WAYS;
    full = 1'b1;
    free_way = -1;
    for (int i = 0; i < WAYS; i++) begin
      t = tags[i*TAG_W +: TAG_W];
      if (!vld[i]) begin
        full = 1'b0;
        if (free_way < 0) free_way = i;
      end
      if (!hit && vld[i] && t == tag) begin
        hit = 1'b1;
        way = i;
        lat = i + 1;
      end
    end
    if (!hit) way = full ? rr_m : free_way;
  endtask

  task automatic lookup(input string name, input logic [WAYS*TAG_W-1:0] tags,
                        input logic [WAYS-1:0] vld, input logic [TAG_W-1:0] tag,
                        input int hold, input int lit_hit, input int lit_way, input int lit_lat);
    int lat;
    int edges;
    model(tags, vld, tag, exp_hit, exp_way, exp_full, lat);
    check({name, "_model_hit"}, int'(exp_hit), lit_hit);
    check({name, "_model_way"}, exp_way, lit_way);
    check({name, "_model_lat"}, lat, lit_lat);
    check({name, "_ready_before"}, int'(req_ready), 1);
    req_tag   = tag;
    way_tags  = tags;
    way_valid = vld;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    busy_m    = 1'b1;
    req_valid = 1'b0;
    req_tag   = ~tag;
    way_tags  = {$urandom(), $urandom()};
    way_valid = ~vld;
    edges = 0;
    while (!resp_valid && edges < 16) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({name, "_latency"}, edges, lat);
    check({name, "_hit"}, int'(resp_hit), int'(exp_hit));
    check({name, "_way"}, int'(resp_way), exp_way);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({name, "_held_valid"}, int'(resp_valid), 1);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    busy_m = 1'b0;
    if (!exp_hit && exp_full) rr_m = (rr_m + 1) % WAYS;
    check({name, "_valid_drop"}, int'(resp_valid), 0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_tag    = 8'h00;
    way_tags   = 32'h0;
    way_valid  = 4'b0000;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_resp_valid", int'(resp_valid), 0);
    check("rst_resp_hit", int'(resp_hit), 0);
    check("rst_resp_way", int'(resp_way), 0);
    check("rst_set_full", int'(set_full), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    lookup("hit_way2",   32'h44332211, 4'b1111, 8'h33, 0, 1, 2, 3);
    lookup("dup_low",    32'h00005A5A, 4'b0011, 8'h5A, 0, 1, 0, 1);
    lookup("skip_inval", 32'h7F7F7F7F, 4'b1010, 8'h7F, 0, 1, 1, 2);
    lookup("all_inval",  32'h7F7F7F7F, 4'b0000, 8'h7F, 0, 0, 0, 4);
    lookup("rr_miss0",   32'h04030201, 4'b1111, 8'h99, 0, 0, 0, 4);
    lookup("rr_miss1",   32'h04030201, 4'b1111, 8'h99, 0, 0, 1, 4);
    lookup("rr_miss2",   32'h04030201, 4'b1111, 8'h99, 0, 0, 2, 4);
    lookup("rr_miss3",   32'h04030201, 4'b1111, 8'h99, 0, 0, 3, 4);
    lookup("rr_wrap",    32'h04030201, 4'b1111, 8'h99, 5, 0, 0, 4);
    lookup("rr_after",   32'h04030201, 4'b1111, 8'h99, 0, 0, 1, 4);
    lookup("free_way2",  32'h04030201, 4'b1011, 8'h99, 3, 0, 2, 4);
    lookup("rr_kept",    32'h04030201, 4'b1111, 8'h99, 0, 0, 2, 4);
    lookup("hit_way3",   32'hA0B0C0D0, 4'b1111, 8'hA0, 2, 1, 3, 4);

    // Abort a lookup once the walk has reached way 1.
    req_tag   = 8'h99;
    way_tags  = 32'h04030201;
    way_valid = 4'b1111;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    busy_m    = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst    = 1'b1;
    busy_m = 1'b0;
    rr_m   = 0;
    @(negedge clk);
    check("abort_resp_valid", int'(resp_valid), 0);
    check("abort_req_ready", int'(req_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("abort_no_resp", int'(resp_valid), 0);
    end

    lookup("post_rst_miss", 32'h04030201, 4'b1111, 8'h99, 0, 0, 0, 4);
    lookup("post_rst_hit",  32'h04030201, 4'b1111, 8'h02, 0, 1, 1, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
